// File: rtl/pc_fetch_unit_pkg.sv
// Shared fetch-stage constants: FSM encoding,
// PC width and default reset vector.
package pc_fetch_unit_pkg;

  localparam int PC_WIDTH = 32;

  localparam logic [PC_WIDTH-1:0] RESET_VECTOR =
    32'h0000_0000;

  localparam logic [1:0] PCF_BOOT   = 2'd0;
  localparam logic [1:0] PCF_RUN    = 2'd1;
  localparam logic [1:0] PCF_HALTED = 2'd2;

endpackage

// File: rtl/pc_incr32.sv
// Combinational +1 adder for the PC path.
// Wraps modulo 2^WIDTH with no carry out.
import pc_fetch_unit_pkg::*;

module pc_incr32 #(
  parameter int WIDTH = PC_WIDTH
) (
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_inc
);

  assign pc_inc = pc + {{(WIDTH-1){1'b0}}, 1'b1};

endmodule

// File: rtl/pc_fetch_unit.sv
// PC stage: holds the PC, issues fetches over
// valid/ready, takes redirects and halt/resume.
import pc_fetch_unit_pkg::*;

module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = RESET_VECTOR,
  parameter int          WIDTH    = PC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             halt,
  input  logic             resume,
  input  logic             fetch_ready,
  output logic             fetch_valid,
  output logic [WIDTH-1:0] fetch_pc,
  output logic [WIDTH-1:0] pc_next_seq,
  output logic             halted,
  output logic [31:0]      fetch_count
);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_inc;
  logic [31:0]      cnt;
  logic             fire;

  pc_incr32 #(.WIDTH(WIDTH)) u_incr (
    .pc     (pc),
    .pc_inc (pc_inc)
  );

  assign fetch_valid = (state == PCF_RUN);
  assign halted      = (state == PCF_HALTED);
  assign fire        = fetch_valid & fetch_ready;
  assign fetch_pc    = pc;
  assign pc_next_seq = pc_inc;
  assign fetch_count = cnt;

  // halt always wins over resume
  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == PCF_BOOT):
        state_nxt = halt ? PCF_HALTED : PCF_RUN;
      (state == PCF_RUN):
        if (halt) state_nxt = PCF_HALTED;
      (state == PCF_HALTED):
        if (resume && !halt) state_nxt = PCF_RUN;
      default:
        state_nxt = PCF_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= PCF_BOOT;
      pc    <= RESET_PC[WIDTH-1:0];
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (redirect_valid) begin
        pc <= redirect_pc;
      end else if (fire) begin
        pc <= pc_inc;
      end
      if (fire) begin
        cnt <= cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed plan plus
// random traffic against a behavioural model.
`timescale 1ns/1ps

module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        resume;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] pc_next_seq;
  logic        halted;
  logic [31:0] fetch_count;

  int n_tests;
  int n_fail;

  // reference model
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  bit          m_boot;
  bit          m_halt;

  pc_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .resume         (resume),
    .fetch_ready    (fetch_ready),
    .fetch_valid    (fetch_valid),
    .fetch_pc       (fetch_pc),
    .pc_next_seq    (pc_next_seq),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic chk_all();
    bit v;
    v = !m_boot && !m_halt;
    chk("valid", {31'd0, fetch_valid}, {31'd0, v});
    chk("halted", {31'd0, halted}, {31'd0, m_halt});
    chk("pc", fetch_pc, m_pc);
    chk("nseq", pc_next_seq, m_pc + 32'd1);
    chk("count", fetch_count, m_cnt);
  endtask

  // one clock: check current outputs, apply inputs,
  // advance model, step to just after the edge
  task automatic cyc(
    input bit          rn,
    input bit          rv,
    input logic [31:0] rpc,
    input bit          h,
    input bit          r,
    input bit          rdy
  );
    bit fire;
    rst_n          = rn;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt           = h;
    resume         = r;
    fetch_ready    = rdy;
    chk_all();
    fire = !m_boot && !m_halt && rdy;
    @(posedge clk);
    #1;
    if (!rn) begin
      m_pc   = 32'h0;
      m_cnt  = 32'h0;
      m_boot = 1'b1;
      m_halt = 1'b0;
    end else begin
      if (rv) m_pc = rpc;
      else if (fire) m_pc = m_pc + 32'd1;
      if (fire) m_cnt = m_cnt + 32'd1;
      if (m_boot) begin
        m_boot = 1'b0;
        m_halt = h;
      end else if (m_halt) begin
        if (r && !h) m_halt = 1'b0;
      end else if (h) begin
        m_halt = 1'b1;
      end
    end
  endtask

  task automatic run(input bit rdy);
    cyc(1, 0, 32'h0, 0, 0, rdy);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_pc    = 32'h0;
    m_cnt   = 32'h0;
    m_boot  = 1'b1;
    m_halt  = 1'b0;
    rst_n   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt    = 1'b0;
    resume  = 1'b0;
    fetch_ready = 1'b0;
    @(posedge clk);
    #1;

    // reset and boot
    repeat (3) cyc(0, 0, 32'h0, 0, 0, 1);
    chk("rst_pc", fetch_pc, 32'h0);
    chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
    run(1);
    repeat (4) run(1);
    chk("boot_cnt", fetch_count, 32'd4);
    chk("boot_pc", fetch_pc, 32'd4);
    run(1);

    // backpressure at pc 5
    repeat (3) run(0);
    chk("bp_pc", fetch_pc, 32'd5);
    chk("bp_cnt", fetch_count, 32'd5);
    run(1);
    chk("bp_rel", fetch_pc, 32'd6);

    // redirect with and without fire
    repeat (2) run(1);
    cyc(1, 1, 32'h100, 0, 0, 1);
    chk("redir_pc", fetch_pc, 32'h100);
    chk("redir_cnt", fetch_count, 32'd9);
    cyc(1, 1, 32'h100, 0, 0, 0);
    chk("redir_stall", fetch_pc, 32'h100);

    // halt / resume
    cyc(1, 1, 32'd10, 0, 0, 0);
    cyc(1, 0, 32'h0, 1, 0, 1);
    chk("halt_pc", fetch_pc, 32'd11);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    cyc(1, 0, 32'h0, 1, 1, 1);
    chk("halt_wins", {31'd0, halted}, 32'd1);
    cyc(1, 0, 32'h0, 0, 1, 1);
    chk("resume_pc", fetch_pc, 32'd11);
    cyc(1, 0, 32'h0, 1, 0, 0);
    cyc(1, 1, 32'h40, 0, 0, 1);
    chk("hredir_v", {31'd0, fetch_valid}, 32'd0);
    cyc(1, 0, 32'h0, 0, 1, 1);
    chk("hredir_pc", fetch_pc, 32'h40);

    // wrap
    cyc(1, 1, 32'hFFFF_FFFF, 0, 0, 0);
    chk("wrap_nseq", pc_next_seq, 32'h0);
    run(1);
    chk("wrap_pc", fetch_pc, 32'h0);

    // reset while halted, and during a stall
    cyc(1, 0, 32'h0, 1, 0, 0);
    cyc(0, 0, 32'h0, 0, 0, 1);
    chk("mrst_cnt", fetch_count, 32'd0);
    run(0);
    cyc(1, 1, 32'h20, 0, 0, 0);
    run(0);
    cyc(0, 0, 32'h0, 0, 0, 0);
    chk("mrst_pc", fetch_pc, 32'h0);
    chk("mrst_boot", {31'd0, fetch_valid}, 32'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      bit          rn, rv, h, r, rdy;
      logic [31:0] rpc;
      rn  = ($urandom_range(99) >= 2);
      rv  = ($urandom_range(99) < 12);
      h   = ($urandom_range(99) < 8);
      r   = ($urandom_range(99) < 30);
      rdy = ($urandom_range(99) < 70);
      rpc = $urandom;
      if ($urandom_range(3) == 0)
        rpc = 32'hFFFF_FFFF - $urandom_range(2);
      cyc(rn, rv, rpc, h, r, rdy);
    end
    chk_all();

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
